// File: rtl/i2c_mpu_responder_pkg.sv
// Shared types and constants for the MPU-style I2C register responder.
package i2c_mpu_responder_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned SENSOR_BYTES = 14;
  localparam int unsigned SENSOR_W     = SENSOR_BYTES * BYTE_W;
  localparam int unsigned BIT_CNT_W    = 4;

  // Bit counter values: last data bit sampled, and full byte received/sent
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] BYTE_DONE = BIT_CNT_W'(8);

  // Register map
  localparam logic [BYTE_W-1:0] ADDR_SMPLRT_DIV   = 8'h19;
  localparam logic [BYTE_W-1:0] ADDR_CONFIG       = 8'h1A;
  localparam logic [BYTE_W-1:0] ADDR_GYRO_CONFIG  = 8'h1B;
  localparam logic [BYTE_W-1:0] ADDR_ACCEL_CONFIG = 8'h1C;
  localparam logic [BYTE_W-1:0] ADDR_ACCEL_XOUT_H = 8'h3B;
  localparam logic [BYTE_W-1:0] ADDR_GYRO_ZOUT_L  = 8'h48;
  localparam logic [BYTE_W-1:0] ADDR_PWR_MGMT_1   = 8'h6B;
  localparam logic [BYTE_W-1:0] ADDR_WHO_AM_I     = 8'h75;

  localparam logic [BYTE_W-1:0] PWR_MGMT_1_RST = 8'h40;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for SCL/SDA plus edge, START and STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_sync,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_prev_q, scl_prev_d;
  logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_prev_q, sda_prev_d;

  // Next values of the synchroniser chains and the edge-history flops
  always_comb begin
    scl_meta_d = scl_i;
    scl_sync_d = scl_meta_q;
    scl_prev_d = scl_sync_q;
    sda_meta_d = sda_i;
    sda_sync_d = sda_meta_q;
    sda_prev_d = sda_sync_q;
  end

  // Reset to the idle-bus level so no spurious edge appears after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_sync   = sda_sync_q;
  assign scl_rise_c = scl_sync_q & ~scl_prev_q;
  assign scl_fall_c = ~scl_sync_q & scl_prev_q;
  assign start_c    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_c     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

endmodule

// File: rtl/i2c_mpu_responder.sv
// I2C slave exposing an MPU-6050 style register map.
// Optional MPU_RESP_SNAPSHOT_EN: freezes the 14 sensor bytes at the read
// address ACK so a burst read is tear-free.
module i2c_mpu_responder
  import i2c_mpu_responder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scl_i,
  input  logic               sda_i,
  output logic               sda_oe,
  input  logic signed [15:0] accel_x,
  input  logic signed [15:0] accel_y,
  input  logic signed [15:0] accel_z,
  input  logic signed [15:0] temp,
  input  logic signed [15:0] gyro_x,
  input  logic signed [15:0] gyro_y,
  input  logic signed [15:0] gyro_z,
  input  logic               sample_valid,
  output logic               wr_valid,
  output logic [7:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               busy
);

  logic sda_sync, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_sync  (sda_sync),
    .scl_rise_c(scl_rise_c),
    .scl_fall_c(scl_fall_c),
    .start_c   (start_c),
    .stop_c    (stop_c)
  );

  state_e                  state_q, state_d;
  logic [BIT_CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]       shift_q, shift_d;
  logic [BYTE_W-1:0]       tx_q, tx_d;
  logic [BYTE_W-1:0]       ptr_q, ptr_d;
  logic                    rw_q, rw_d;
  logic                    sda_oe_q, sda_oe_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [BYTE_W-1:0]       wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]       wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic [BYTE_W-1:0]       smplrt_q, smplrt_d;
  logic [BYTE_W-1:0]       config_q, config_d;
  logic [BYTE_W-1:0]       gyro_cfg_q, gyro_cfg_d;
  logic [BYTE_W-1:0]       accel_cfg_q, accel_cfg_d;
  logic [BYTE_W-1:0]       pwr_mgmt_q, pwr_mgmt_d;
  logic [SENSOR_W-1:0]     shadow_q, shadow_d;
`ifdef MPU_RESP_SNAPSHOT_EN
  logic [SENSOR_W-1:0]     snap_q, snap_d;
`endif

  logic [SENSOR_W-1:0]     rd_bank_c;
  logic [BYTE_W-1:0]       byte_in_c;
  logic [BYTE_W-1:0]       rd_ptr_c;
  logic [BYTE_W-1:0]       rd_nxt_c;

  // Register read decode; sensor bytes are packed AXH first in the bank
  function automatic logic [BYTE_W-1:0] reg_read(
    input logic [BYTE_W-1:0]   a,
    input logic [SENSOR_W-1:0] bank,
    input logic [BYTE_W-1:0]   r19,
    input logic [BYTE_W-1:0]   r1a,
    input logic [BYTE_W-1:0]   r1b,
    input logic [BYTE_W-1:0]   r1c,
    input logic [BYTE_W-1:0]   r6b
  );
    logic [3:0]          idx;
    logic [SENSOR_W-1:0] sh;
    idx      = 4'(a - ADDR_ACCEL_XOUT_H);
    sh       = bank << {idx, 3'b000};
    reg_read = 8'h00;
    if (a >= ADDR_ACCEL_XOUT_H && a <= ADDR_GYRO_ZOUT_L) begin
      reg_read = sh[SENSOR_W-1 -: BYTE_W];
    end else begin
      case (a)
        ADDR_SMPLRT_DIV:   reg_read = r19;
        ADDR_CONFIG:       reg_read = r1a;
        ADDR_GYRO_CONFIG:  reg_read = r1b;
        ADDR_ACCEL_CONFIG: reg_read = r1c;
        ADDR_PWR_MGMT_1:   reg_read = r6b;
        ADDR_WHO_AM_I:     reg_read = WHO_AM_I_VAL;
        default:           reg_read = 8'h00;
      endcase
    end
  endfunction

`ifdef MPU_RESP_SNAPSHOT_EN
  assign rd_bank_c = snap_q;
`else
  assign rd_bank_c = shadow_q;
`endif

  assign byte_in_c = {shift_q[BYTE_W-2:0], sda_sync};
  assign rd_ptr_c  = reg_read(ptr_q, rd_bank_c, smplrt_q, config_q, gyro_cfg_q,
                              accel_cfg_q, pwr_mgmt_q);
  assign rd_nxt_c  = reg_read(ptr_q + 8'd1, rd_bank_c, smplrt_q, config_q,
                              gyro_cfg_q, accel_cfg_q, pwr_mgmt_q);

  // Protocol FSM: bits in on SCL rise, SDA drive changes only on SCL fall
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    smplrt_d    = smplrt_q;
    config_d    = config_q;
    gyro_cfg_d  = gyro_cfg_q;
    accel_cfg_d = accel_cfg_q;
    pwr_mgmt_d  = pwr_mgmt_q;
    shadow_d    = sample_valid ? {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z}
                               : shadow_q;
`ifdef MPU_RESP_SNAPSHOT_EN
    snap_d      = snap_q;
`endif

    if (start_c) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_c) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise_c) begin
            shift_d = byte_in_c;
            cnt_d   = cnt_q + 1'b1;
          end else if (scl_fall_c && cnt_q == BYTE_DONE) begin
            cnt_d = '0;
            if (shift_q[BYTE_W-1:1] == DEV_ADDR) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
`ifdef MPU_RESP_SNAPSHOT_EN
              if (shift_q[0]) snap_d = shadow_q;
`endif
            end else begin
              state_d = IDLE;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall_c) begin
            if (rw_q) begin
              state_d  = RDATA;
              tx_d     = rd_ptr_c;
              sda_oe_d = ~rd_ptr_c[BYTE_W-1];
            end else begin
              state_d  = PTR;
              sda_oe_d = 1'b0;
            end
          end
        end

        PTR: begin
          if (scl_rise_c) begin
            shift_d = byte_in_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) ptr_d = byte_in_c;
          end else if (scl_fall_c && cnt_q == BYTE_DONE) begin
            cnt_d    = '0;
            state_d  = PTR_ACK;
            sda_oe_d = 1'b1;
          end
        end

        PTR_ACK, WDATA_ACK: begin
          if (scl_fall_c) begin
            state_d  = WDATA;
            sda_oe_d = 1'b0;
          end
        end

        WDATA: begin
          if (scl_rise_c) begin
            shift_d = byte_in_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_in_c;
              ptr_d      = ptr_q + 8'd1;
              case (ptr_q)
                ADDR_SMPLRT_DIV:   smplrt_d    = byte_in_c;
                ADDR_CONFIG:       config_d    = byte_in_c;
                ADDR_GYRO_CONFIG:  gyro_cfg_d  = byte_in_c;
                ADDR_ACCEL_CONFIG: accel_cfg_d = byte_in_c;
                ADDR_PWR_MGMT_1:   pwr_mgmt_d  = byte_in_c;
                default: ;
              endcase
            end
          end else if (scl_fall_c && cnt_q == BYTE_DONE) begin
            cnt_d    = '0;
            state_d  = WDATA_ACK;
            sda_oe_d = 1'b1;
          end
        end

        RDATA: begin
          if (scl_rise_c) begin
            cnt_d = cnt_q + 1'b1;
          end else if (scl_fall_c) begin
            if (cnt_q == BYTE_DONE) begin
              cnt_d    = '0;
              state_d  = RDATA_ACK;
              sda_oe_d = 1'b0;
            end else begin
              tx_d     = {tx_q[BYTE_W-2:0], 1'b0};
              sda_oe_d = ~tx_q[BYTE_W-2];
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise_c) begin
            shift_d = byte_in_c;
          end else if (scl_fall_c) begin
            if (!shift_q[0]) begin
              state_d  = RDATA;
              ptr_d    = ptr_q + 8'd1;
              tx_d     = rd_nxt_c;
              sda_oe_d = ~rd_nxt_c[BYTE_W-1];
            end else begin
              state_d  = IDLE;
            end
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset releases SDA asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      smplrt_q    <= '0;
      config_q    <= '0;
      gyro_cfg_q  <= '0;
      accel_cfg_q <= '0;
      pwr_mgmt_q  <= PWR_MGMT_1_RST;
      shadow_q    <= '0;
`ifdef MPU_RESP_SNAPSHOT_EN
      snap_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      smplrt_q    <= smplrt_d;
      config_q    <= config_d;
      gyro_cfg_q  <= gyro_cfg_d;
      accel_cfg_q <= accel_cfg_d;
      pwr_mgmt_q  <= pwr_mgmt_d;
      shadow_q    <= shadow_d;
`ifdef MPU_RESP_SNAPSHOT_EN
      snap_q      <= snap_d;
`endif
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_mpu_responder.sv
// Directed bench for i2c_mpu_responder: bit-banged I2C master on an open-drain bus.
module tb_i2c_mpu_responder;

  localparam int Q = 15;  // quarter SCL bit time in clk cycles

  localparam logic [111:0] EXP_OLD =
    112'h1234_5678_9ABC_DEF0_1357_2468_ABCD;
`ifdef MPU_RESP_SNAPSHOT_EN
  localparam logic [111:0] EXP_MIX = EXP_OLD;
`else
  localparam logic [111:0] EXP_MIX =
    112'h1234_5678_9ABC_4444_5555_6666_7777;
`endif

  logic clk, rst_n, scl_m, sda_m, sda_bus;
  logic sda_oe, sample_valid, wr_valid, busy;
  logic [7:0] wr_addr, wr_data;
  logic signed [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;

  int checks, failures;
  int wv_cnt, oe_cnt;
  logic [7:0] last_wa, last_wd;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_mpu_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_oe      (sda_oe),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .accel_z     (accel_z),
    .temp        (temp),
    .gyro_x      (gyro_x),
    .gyro_y      (gyro_y),
    .gyro_z      (gyro_z),
    .sample_valid(sample_valid),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe write pulses and SDA drive, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_valid) begin
      wv_cnt  = wv_cnt + 1;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic bit_cycle(input logic tx, output logic rx);
    sda_m = tx;   wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    rx = sda_bus; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    logic [7:0] s;
    s = b;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(s[7], r);
      s = {s[6:0], 1'b0};
    end
    bit_cycle(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    logic r;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, r);
      b = {b[6:0], r};
    end
    bit_cycle(~mack, r);
  endtask

  // Set pointer, repeated START, read n bytes (first byte ends up highest)
  task automatic read_burst(input logic [7:0] a, input int n,
                            output logic [127:0] data, output int nacks);
    logic ak;
    logic [7:0] b;
    nacks = 0;
    data  = '0;
    i2c_start();
    wr_byte(8'hD0, ak); if (!ak) nacks++;
    wr_byte(a, ak);     if (!ak) nacks++;
    i2c_start();
    wr_byte(8'hD1, ak); if (!ak) nacks++;
    for (int i = 0; i < n; i++) begin
      rd_byte(i != n - 1, b);
      data = {data[119:0], b};
    end
    i2c_stop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; sample_valid = 1'b0;
    accel_x = '0; accel_y = '0; accel_z = '0; temp = '0;
    gyro_x = '0; gyro_y = '0; gyro_z = '0;
    wait_clk(4);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL rst_wr_valid got=%b exp=0", wr_valid); end
    checks++; if (wr_addr !== 8'h00) begin failures++; $display("FAIL rst_wr_addr got=%h exp=00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL rst_wr_data got=%h exp=00", wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_async_reset();
    logic r;
    logic [7:0] s;
    s = 8'hD0;
    i2c_start();
    for (int i = 0; i < 8; i++) begin
      bit_cycle(s[7], r);
      s = {s[6:0], 1'b0};
    end
    sda_m = 1'b1;
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL ack_drive got=%b exp=1", sda_oe); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL async_release got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", busy); end
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_write_pwr();
    logic a0, a1, a2;
    logic [127:0] d;
    int nk, base;
    read_burst(8'h6B, 1, d, nk);
    checks++; if (d[7:0] !== 8'h40) begin failures++; $display("FAIL pwr_reset_val got=%h exp=40", d[7:0]); end
    base = wv_cnt;
    i2c_start();
    wr_byte(8'hD0, a0); wr_byte(8'h6B, a1); wr_byte(8'h00, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL pwr_acks got=%b exp=111", {a0, a1, a2}); end
    checks++; if (wv_cnt - base !== 1) begin failures++; $display("FAIL pwr_wv_count got=%0d exp=1", wv_cnt - base); end
    checks++; if (last_wa !== 8'h6B) begin failures++; $display("FAIL pwr_wr_addr got=%h exp=6b", last_wa); end
    checks++; if (last_wd !== 8'h00) begin failures++; $display("FAIL pwr_wr_data got=%h exp=00", last_wd); end
    read_burst(8'h6B, 1, d, nk);
    checks++; if (d[7:0] !== 8'h00) begin failures++; $display("FAIL pwr_readback got=%h exp=00", d[7:0]); end
  endtask

  task automatic test_who_am_i();
    logic ak;
    logic [7:0] b;
    i2c_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b exp=1", busy); end
    wr_byte(8'hD0, ak); wr_byte(8'h75, ak);
    i2c_start();
    wr_byte(8'hD1, ak);
    rd_byte(1'b0, b);
    i2c_stop();
    checks++; if (b !== 8'h68) begin failures++; $display("FAIL who_am_i got=%h exp=68", b); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_burst();
    logic [127:0] d;
    logic [7:0] got, exp;
    int nk;
    accel_x = 16'h1234; accel_y = 16'h5678; accel_z = 16'h9ABC; temp = 16'hDEF0;
    gyro_x  = 16'h1357; gyro_y  = 16'h2468; gyro_z  = 16'hABCD;
    sample_valid = 1'b1; wait_clk(1); sample_valid = 1'b0;
    read_burst(8'h3B, 14, d, nk);
    checks++; if (nk !== 0) begin failures++; $display("FAIL burst_acks got=%0d exp=0", nk); end
    for (int i = 0; i < 14; i++) begin
      got = 8'(d >> (8 * (13 - i)));
      exp = 8'(EXP_OLD >> (8 * (13 - i)));
      checks++; if (got !== exp) begin failures++; $display("FAIL burst_byte%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_bad_addr();
    logic a0, a1, a2;
    int wb, ob;
    wb = wv_cnt; ob = oe_cnt;
    i2c_start();
    wr_byte(8'hA0, a0); wr_byte(8'h6B, a1); wr_byte(8'h55, a2);
    i2c_stop();
    checks++; if (a0 !== 1'b0) begin failures++; $display("FAIL badaddr_ack got=%b exp=0", a0); end
    checks++; if (oe_cnt - ob !== 0) begin failures++; $display("FAIL badaddr_sda_oe cycles=%0d exp=0", oe_cnt - ob); end
    checks++; if (wv_cnt - wb !== 0) begin failures++; $display("FAIL badaddr_wr_valid got=%0d exp=0", wv_cnt - wb); end
  endtask

  task automatic test_abort();
    logic ak, r;
    logic [7:0] b;
    int base;
    base = wv_cnt;
    i2c_start(); wr_byte(8'hD0, ak); wr_byte(8'h1C, ak); wr_byte(8'h3C, ak); i2c_stop();
    checks++; if (last_wa !== 8'h1C || last_wd !== 8'h3C) begin failures++; $display("FAIL abort_prewrite got=%h/%h exp=1c/3c", last_wa, last_wd); end
    i2c_start(); wr_byte(8'hD0, ak); wr_byte(8'h1C, ak);
    bit_cycle(1'b1, r); bit_cycle(1'b0, r); bit_cycle(1'b1, r); bit_cycle(1'b0, r);
    i2c_stop();
    checks++; if (wv_cnt - base !== 1) begin failures++; $display("FAIL abort_wr_valid got=%0d exp=1", wv_cnt - base); end
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL abort_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", busy); end
    i2c_start(); wr_byte(8'hD1, ak); rd_byte(1'b0, b); i2c_stop();
    checks++; if (b !== 8'h3C) begin failures++; $display("FAIL abort_pointer got=%h exp=3c", b); end
  endtask

  task automatic test_wrap();
    logic ak;
    logic [127:0] d;
    int base, nk;
    base = wv_cnt;
    i2c_start(); wr_byte(8'hD0, ak); wr_byte(8'hFF, ak); wr_byte(8'h11, ak); wr_byte(8'h22, ak); i2c_stop();
    checks++; if (wv_cnt - base !== 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", wv_cnt - base); end
    checks++; if (last_wa !== 8'h00) begin failures++; $display("FAIL wrap_addr got=%h exp=00", last_wa); end
    checks++; if (last_wd !== 8'h22) begin failures++; $display("FAIL wrap_data got=%h exp=22", last_wd); end
    read_burst(8'h00, 1, d, nk);
    checks++; if (d[7:0] !== 8'h00) begin failures++; $display("FAIL unmapped_write got=%h exp=00", d[7:0]); end
  endtask

  task automatic test_back_to_back();
    logic ak;
    logic [127:0] d;
    int nk;
    i2c_start(); wr_byte(8'hD0, ak);
    wr_byte(8'h19, ak); wr_byte(8'h01, ak); wr_byte(8'h02, ak); wr_byte(8'h03, ak); wr_byte(8'h04, ak);
    i2c_stop();
    checks++; if (last_wa !== 8'h1C) begin failures++; $display("FAIL b2b_last_addr got=%h exp=1c", last_wa); end
    read_burst(8'h19, 5, d, nk);
    checks++; if (d[39:0] !== 40'h01_02_03_04_00) begin failures++; $display("FAIL b2b_readback got=%h exp=0102030400", d[39:0]); end
  endtask

  task automatic test_snapshot();
    logic ak;
    logic [7:0] b, exp;
    i2c_start(); wr_byte(8'hD0, ak); wr_byte(8'h3B, ak);
    i2c_start(); wr_byte(8'hD1, ak);
    for (int i = 0; i < 14; i++) begin
      rd_byte(i != 13, b);
      exp = 8'(EXP_MIX >> (8 * (13 - i)));
      checks++; if (b !== exp) begin failures++; $display("FAIL snap_byte%0d got=%h exp=%h", i, b, exp); end
      if (i == 4) begin
        accel_x = 16'h1111; accel_y = 16'h2222; accel_z = 16'h3333; temp = 16'h4444;
        gyro_x  = 16'h5555; gyro_y  = 16'h6666; gyro_z  = 16'h7777;
        sample_valid = 1'b1; wait_clk(1); sample_valid = 1'b0;
      end
    end
    i2c_stop();
  endtask

  initial begin
    checks = 0; failures = 0; wv_cnt = 0; oe_cnt = 0;
    last_wa = 8'h00; last_wd = 8'h00;
    test_reset();
    test_async_reset();
    test_write_pwr();
    test_who_am_i();
    test_burst();
    test_bad_addr();
    test_abort();
    test_wrap();
    test_back_to_back();
    test_snapshot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
